bingo_core: RTL and testbench
=============================

# bingo_core

Parametrised bingo engine for the next-generation game: holds the cards of `PLAYERS` players (`ENTRIES` numbers each) in an internal card memory. For each drawn number it scans every card, strikes matches and keeps a per-player remaining count. It reports full-card winners, including ties. It sits between the keyboard/number-entry front end (card loading) and the PRNG or hack-number source (draws), and replaces the fixed 2-player, 8-entry game logic.

## Interface
- `PLAYERS`, default 2: number of cards, ≥1.
- `ENTRIES`, default 8: numbers per card, ≥1.
- `DATA_WIDTH`, default 8: number width. Value 0 is reserved as "struck/empty".
- Derived widths:
  - PID_W = max(1, clog2(PLAYERS)).
  - ADDR_W = max(1, clog2(PLAYERS*ENTRIES)).
  - CNT_W = clog2(ENTRIES+1).
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `load_valid`  in  1  card number offered.
- `load_number`  in  DATA_WIDTH  number to store.
- `load_ready`  out  1  high in LOAD state.
- `start`  in  1  single-cycle pulse: begin play from READY, or start a new game from OVER.
- `draw_valid`  in  1  drawn number offered.
- `draw_number`  in  DATA_WIDTH  drawn number.
- `draw_ready`  out  1  high in PLAY state.
- `last_draw`  out  DATA_WIDTH  most recently accepted draw.
- `match_mask`  out  PLAYERS  bit p set if the last draw struck ≥1 entry of player p.
- `remaining`  out  PLAYERS*CNT_W  unstruck count per player; player p occupies bits [p*CNT_W +: CNT_W].
- `winner_mask`  out  PLAYERS  players whose count reached 0.
- `game_over`  out  1  high in OVER state.
- `busy`  out  1  high in SCAN or RESULT.

## Operation
- States: LOAD, READY, PLAY, SCAN, RESULT, OVER. Reset state is LOAD.
- **LOAD**
  - Each `load_valid` cycle writes `load_number` to address `load_ptr` and increments the pointer.
  - Address order: player 0 entries 0..E-1, then player 1, and so on.
  - A loaded 0 counts as already struck: that player's `remaining` is not incremented. `remaining` starts at 0 and counts nonzero loads.
  - The write at address P*E-1 moves to READY.
- **READY**: `start` moves to PLAY. `start` in LOAD is ignored.
- **PLAY**
  - `draw_valid` accepts the draw: latch `last_draw`, clear the match accumulator, move to SCAN.
  - A drawn 0 is accepted but matches nothing.
- **SCAN**
  - Reads address a = 0..P*E-1, one per cycle, through the synchronous-read memory.
  - Compare happens one cycle later. On match with a nonzero entry: write 0 to that address, decrement the owning player's count, set its accumulator bit.
  - Duplicate values on one card are all struck by one draw.
  - Re-drawing a number already struck matches nothing.
- **RESULT** (one cycle)
  - Updates `match_mask` from the accumulator.
  - Sets `winner_mask` to the bits of players with count 0 and a nonzero card.
  - If any winner exists, go to OVER; otherwise go to PLAY.
- **OVER**
  - Outputs hold.
  - `draw_valid` is ignored.
  - `start` returns to LOAD with `load_ptr`=0 and counts, masks and `last_draw` cleared. Memory contents are overwritten by the next load.
- Inputs not listed for the current state are ignored. A player whose whole card is 0 never wins.
- Counts never underflow, because only nonzero entries decrement.

## Timing
- On `rst`, registered outputs are cleared the following edge:
  - `load_ready`=1.
  - `draw_ready`, `busy`, `game_over`, `match_mask`, `winner_mask`, `remaining`, `last_draw` = 0.
  - `load_ptr`=0.
- Reset asserted mid-SCAN aborts the scan. No further memory writes occur after the reset edge.
- All outputs are registered, Moore-style from state or datapath registers.
- Load: one number per cycle. `load_ready` is low the cycle after the final write.
- Draw accepted at edge t:
  - `busy`=1 from t+1.
  - SCAN lasts P*E+1 cycles (read pipeline drain).
  - RESULT occurs at cycle t+P*E+2.
  - `match_mask`, `remaining`, `winner_mask` and `draw_ready`/`game_over` are valid from cycle t+P*E+3.
- `remaining` may change mid-SCAN. It is only guaranteed stable when `busy`=0.
- Memory: one write port and one sync-read port. A write to address a and a read of a+1 happen in the same cycle; no same-address read/write collision occurs.

## Structure
- Package `bingo_pkg`:
  - State enum `bingo_state_t`.
  - Reserved `EMPTY_NUM` = 0.
  - Width helper functions for PID_W, ADDR_W and CNT_W.
- Sub-module `card_mem`:
  - Parameters ENTRIES, ADDR_WIDTH, DATA_WIDTH.
  - One synchronous write port and one synchronous read port, no reset on the array.
  - Natural successor to the current game memory.
- Top-level: FSM, `load_ptr`/`scan_ptr` counters, compare pipeline register, per-player count array, and address-to-player divide by ENTRIES (implemented as a player/entry counter pair, not a divider).

## Test plan
All scenarios use P=2, E=4, W=8.
- **Load and start**: after `rst`, load 1,2,3,4,3,5,6,7. `load_ready` falls after the 8th write; `start` gives `draw_ready`=1 and `remaining`={4,4}. `start` sent before the 8th load is ignored.
- **Shared match**: draw 3 → `draw_ready` returns 11 cycles after acceptance with `match_mask`=11, `remaining`={3,3} and `last_draw`=3. `load_valid` held during PLAY changes nothing.
- **Miss, re-draw and zero**: draw 9, then 3 again, then 0 → each gives `match_mask`=00 and counts stay {3,3}.
- **Single winner**: draw 1, 2, 4 → after 4, `winner_mask`=01, `game_over`=1, `draw_ready`=0. A further `draw_valid` is ignored; `start` returns to LOAD with all counts 0.
- **Tie and duplicates**: cards {1,1,2,2} and {2,1,2,1}. Draw 1 → `remaining`={2,2}. Draw 2 → `winner_mask`=11.
- **Reset mid-scan**: assert `rst` 3 cycles into SCAN → next cycle shows all reset values and `load_ready`=1. A fresh load and game then behaves as in the load-and-start scenario.

Source files
------------

// File: rtl/bingo_pkg.sv
// bingo_pkg: shared types and width helpers for the bingo engine.
//   bingo_state_t : top-level game FSM states
//   EMPTY_NUM     : reserved number meaning "struck / empty entry"
//   pid_w/addr_w/cnt_w : derived width helpers used by bingo_core
package bingo_pkg;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_READY,
      ST_PLAY,
      ST_SCAN,
      ST_RESULT,
      ST_OVER
   } bingo_state_t;

   localparam int EMPTY_NUM = 0;

   // Player index width, at least one bit even for a single player.
   function automatic int pid_w(input int players);
      return (players > 1) ? $clog2(players) : 1;
   endfunction

   // Address width over a depth, at least one bit even for depth 1.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Counter width able to hold 0..entries.
   function automatic int cnt_w(input int entries);
      return $clog2(entries + 1);
   endfunction

endpackage

// File: rtl/card_mem.sv
// card_mem: card storage, one synchronous write port and one synchronous
// read port. The array has no reset; contents are rewritten by each load.
//   clk              : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr    : read request, data appears on rd_data after the edge
//   rd_data          : registered read data
module card_mem #(
   parameter int ENTRIES    = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/bingo_core.sv
// bingo_core: multi-player bingo engine.
// Loads PLAYERS cards of ENTRIES numbers, then for each draw scans the whole
// card memory, strikes matching entries, keeps a per-player remaining count
// and reports full-card winners (ties included).
//   clk, rst                  : clock, synchronous active-high reset
//   load_valid/load_number    : card number entry, accepted while load_ready
//   load_ready                : high in LOAD
//   start                     : READY->PLAY, or OVER->LOAD (new game)
//   draw_valid/draw_number    : drawn number, accepted while draw_ready
//   draw_ready                : high in PLAY
//   last_draw                 : most recently accepted draw
//   match_mask                : players struck by the last draw
//   remaining                 : packed per-player unstruck counts
//   winner_mask               : players with a completed card
//   game_over                 : high in OVER
//   busy                      : high in SCAN or RESULT
module bingo_core
   import bingo_pkg::*;
#(
   parameter int PLAYERS    = 2,
   parameter int ENTRIES    = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 load_valid,
   input  logic [DATA_WIDTH-1:0]                load_number,
   output logic                                 load_ready,
   input  logic                                 start,
   input  logic                                 draw_valid,
   input  logic [DATA_WIDTH-1:0]                draw_number,
   output logic                                 draw_ready,
   output logic [DATA_WIDTH-1:0]                last_draw,
   output logic [PLAYERS-1:0]                   match_mask,
   output logic [PLAYERS*cnt_w(ENTRIES)-1:0]    remaining,
   output logic [PLAYERS-1:0]                   winner_mask,
   output logic                                 game_over,
   output logic                                 busy
);

   localparam int NUM    = PLAYERS * ENTRIES;
   localparam int PID_W  = pid_w(PLAYERS);
   localparam int ADDR_W = addr_w(NUM);
   localparam int CNT_W  = cnt_w(ENTRIES);
   localparam int ENT_W  = addr_w(ENTRIES);
   localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(NUM - 1);
   localparam logic [ENT_W-1:0]      LAST_ENT  = ENT_W'(ENTRIES - 1);
   localparam logic [DATA_WIDTH-1:0] EMPTY     = DATA_WIDTH'(EMPTY_NUM);

   bingo_state_t state, state_nx;

   // Address counters, each paired with a player/entry counter so the owning
   // player of an address is known without dividing by ENTRIES.
   logic [ADDR_W-1:0] load_ptr, scan_ptr;
   logic [PID_W-1:0]  load_pid, scan_pid;
   logic [ENT_W-1:0]  load_ent, scan_ent;
   logic              scan_issue;

   logic                  vld_p1;
   logic [ADDR_W-1:0]     addr_p1;
   logic [PID_W-1:0]      pid_p1;
   logic [DATA_WIDTH-1:0] rd_data_p1;
   logic                  hit_p1;

   logic [CNT_W-1:0]   cnt [PLAYERS];
   logic [PLAYERS-1:0] has_card, acc, win;

   logic                  load_fire, draw_fire, new_game;
   logic                  mem_we, mem_re;
   logic [ADDR_W-1:0]     mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   assign load_fire = (state == ST_LOAD) && load_valid;
   assign draw_fire = (state == ST_PLAY) && draw_valid;
   assign new_game  = (state == ST_OVER) && start;
   assign mem_re    = (state == ST_SCAN) && scan_issue;

   // A zero entry is already struck, so a drawn zero never matches.
   assign hit_p1 = vld_p1 && (rd_data_p1 == last_draw) && (rd_data_p1 != EMPTY);

   always_comb begin
      win = '0;
      for (int p = 0; p < PLAYERS; p++)
         win[p] = has_card[p] && (cnt[p] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_LOAD;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_LOAD:   if (load_fire && (load_ptr == LAST_ADDR)) state_nx = ST_READY;
         ST_READY:  if (start) state_nx = ST_PLAY;
         ST_PLAY:   if (draw_valid) state_nx = ST_SCAN;
         // The cycle after the last read issue is the compare drain cycle.
         ST_SCAN:   if (!scan_issue) state_nx = ST_RESULT;
         ST_RESULT: state_nx = (|win) ? ST_OVER : ST_PLAY;
         ST_OVER:   if (start) state_nx = ST_LOAD;
         default:   state_nx = ST_LOAD;
      endcase
   end

   // Loads and strikes never coincide (different states); writes are
   // suppressed on the reset edge so an aborted scan leaves no trace.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = load_ptr;
      mem_wdata = load_number;
      if (load_fire) begin
         mem_we = 1'b1;
      end else if (hit_p1) begin
         mem_we    = 1'b1;
         mem_waddr = addr_p1;
         mem_wdata = EMPTY;
      end
      if (rst) mem_we = 1'b0;
   end

   card_mem #(
      .ENTRIES    (NUM),
      .ADDR_WIDTH (ADDR_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_card_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (mem_waddr),
      .wr_data (mem_wdata),
      .rd_en   (mem_re),
      .rd_addr (scan_ptr),
      .rd_data (rd_data_p1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         load_ptr    <= '0;
         load_pid    <= '0;
         load_ent    <= '0;
         scan_ptr    <= '0;
         scan_pid    <= '0;
         scan_ent    <= '0;
         scan_issue  <= 1'b0;
         vld_p1      <= 1'b0;
         last_draw   <= '0;
         match_mask  <= '0;
         winner_mask <= '0;
         acc         <= '0;
         has_card    <= '0;
      end else begin
         vld_p1 <= mem_re;
         if (load_fire) begin
            load_ptr <= load_ptr + ADDR_W'(1);
            if (load_ent == LAST_ENT) begin
               load_ent <= '0;
               load_pid <= load_pid + PID_W'(1);
            end else begin
               load_ent <= load_ent + ENT_W'(1);
            end
            if (load_number != EMPTY) has_card[load_pid] <= 1'b1;
         end
         if (draw_fire) begin
            last_draw  <= draw_number;
            acc        <= '0;
            scan_issue <= 1'b1;
            scan_ptr   <= '0;
            scan_pid   <= '0;
            scan_ent   <= '0;
         end
         if (mem_re) begin
            if (scan_ptr == LAST_ADDR) scan_issue <= 1'b0;
            scan_ptr <= scan_ptr + ADDR_W'(1);
            if (scan_ent == LAST_ENT) begin
               scan_ent <= '0;
               scan_pid <= scan_pid + PID_W'(1);
            end else begin
               scan_ent <= scan_ent + ENT_W'(1);
            end
         end
         if (hit_p1) acc[pid_p1] <= 1'b1;
         if (state == ST_RESULT) begin
            match_mask  <= acc;
            winner_mask <= win;
         end
         if (new_game) begin
            load_ptr    <= '0;
            load_pid    <= '0;
            load_ent    <= '0;
            last_draw   <= '0;
            match_mask  <= '0;
            winner_mask <= '0;
            acc         <= '0;
            has_card    <= '0;
         end
      end
   end

   // Read stage -> compare stage: address and owner travel with the read data.
   always_ff @(posedge clk) begin
      addr_p1 <= scan_ptr;
      pid_p1  <= scan_pid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < PLAYERS; p++) cnt[p] <= '0;
      end else begin
         for (int p = 0; p < PLAYERS; p++) begin
            if (new_game)
               cnt[p] <= '0;
            else if (load_fire && (load_number != EMPTY) && (load_pid == PID_W'(p)))
               cnt[p] <= cnt[p] + CNT_W'(1);
            else if (hit_p1 && (pid_p1 == PID_W'(p)))
               cnt[p] <= cnt[p] - CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < PLAYERS; g++) begin : g_rem
      assign remaining[g*CNT_W +: CNT_W] = cnt[g];
   end

   assign load_ready = (state == ST_LOAD);
   assign draw_ready = (state == ST_PLAY);
   assign game_over  = (state == ST_OVER);
   assign busy       = (state == ST_SCAN) || (state == ST_RESULT);

endmodule

// File: tb/tb_bingo_core.sv
// tb_bingo_core: self-checking bench for bingo_core (2 players, 4 entries,
// 8-bit numbers). Directed game scenarios followed by randomized games, all
// compared against a card-level reference model held in plain arrays.
module tb_bingo_core;

   localparam int P  = 2;
   localparam int E  = 4;
   localparam int W  = 8;
   localparam int N  = P * E;
   localparam int CW = $clog2(E + 1);

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            load_valid = 1'b0;
   logic [W-1:0]    load_number = '0;
   logic            load_ready;
   logic            start = 1'b0;
   logic            draw_valid = 1'b0;
   logic [W-1:0]    draw_number = '0;
   logic            draw_ready;
   logic [W-1:0]    last_draw;
   logic [P-1:0]    match_mask;
   logic [P*CW-1:0] remaining;
   logic [P-1:0]    winner_mask;
   logic            game_over;
   logic            busy;

   bingo_core #(.PLAYERS(P), .ENTRIES(E), .DATA_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_number (load_number),
      .load_ready  (load_ready),
      .start       (start),
      .draw_valid  (draw_valid),
      .draw_number (draw_number),
      .draw_ready  (draw_ready),
      .last_draw   (last_draw),
      .match_mask  (match_mask),
      .remaining   (remaining),
      .winner_mask (winner_mask),
      .game_over   (game_over),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: card contents, struck entries become 0.
   int card [P][E];
   bit has  [P];
   int ld   [N];
   int m_last;
   int m_mm;
   int m_wm;
   bit m_over;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int mrem(input int p);
      int c = 0;
      for (int e = 0; e < E; e++) if (card[p][e] != 0) c++;
      return c;
   endfunction

   function automatic int exp_rem();
      int r = 0;
      for (int p = 0; p < P; p++) r = r | (mrem(p) << (p * CW));
      return r;
   endfunction

   task automatic model_clear();
      for (int p = 0; p < P; p++) begin
         has[p] = 0;
         for (int e = 0; e < E; e++) card[p][e] = 0;
      end
      m_last = 0; m_mm = 0; m_wm = 0; m_over = 0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_load_ready"}, 32'(load_ready), 1);
      chk({tag, "_draw_ready"}, 32'(draw_ready), 0);
      chk({tag, "_busy"},       32'(busy), 0);
      chk({tag, "_game_over"},  32'(game_over), 0);
      chk({tag, "_match"},      32'(match_mask), 0);
      chk({tag, "_winner"},     32'(winner_mask), 0);
      chk({tag, "_remaining"},  32'(remaining), 0);
      chk({tag, "_last_draw"},  32'(last_draw), 0);
   endtask

   task automatic check_play(input string tag);
      chk({tag, "_last_draw"},  32'(last_draw), 32'(m_last));
      chk({tag, "_match"},      32'(match_mask), 32'(m_mm));
      chk({tag, "_winner"},     32'(winner_mask), 32'(m_wm));
      chk({tag, "_remaining"},  32'(remaining), 32'(exp_rem()));
      chk({tag, "_game_over"},  32'(game_over), 32'(m_over));
      chk({tag, "_draw_ready"}, 32'(draw_ready), 32'(!m_over));
      chk({tag, "_busy"},       32'(busy), 0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      load_valid = 1'b0; start = 1'b0; draw_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      model_clear();
      check_idle("reset");
   endtask

   task automatic load_card(input bit poke_start, input bit gaps);
      for (int i = 0; i < N; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            @(negedge clk); load_valid = 1'b0; start = 1'b0;
         end
         @(negedge clk);
         if (i == N - 1) chk("load_ready_before_last", 32'(load_ready), 1);
         load_valid  = 1'b1;
         load_number = 8'(ld[i]);
         start       = poke_start && (i == 4);
         card[i / E][i % E] = ld[i];
         if (ld[i] != 0) has[i / E] = 1;
      end
      @(negedge clk); load_valid = 1'b0; start = 1'b0;
      chk("load_ready_after_last", 32'(load_ready), 0);
      chk("ready_no_draw",         32'(draw_ready), 0);
      chk("load_remaining",        32'(remaining), 32'(exp_rem()));
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_draw_ready", 32'(draw_ready), 1);
      chk("start_remaining",  32'(remaining), 32'(exp_rem()));
   endtask

   task automatic do_draw(input int n);
      int lat;
      @(negedge clk); draw_valid = 1'b1; draw_number = 8'(n);
      @(negedge clk); draw_valid = 1'b0;
      if (m_over) begin
         chk("over_draw_busy", 32'(busy), 0);
         chk("over_draw_last", 32'(last_draw), 32'(m_last));
         chk("over_draw_over", 32'(game_over), 1);
         return;
      end
      chk("draw_busy", 32'(busy), 1);
      lat = 1;
      while (busy === 1'b1 && lat < 60) begin
         @(negedge clk); lat++;
      end
      chk("draw_latency", 32'(lat), 32'(N + 3));
      m_last = n;
      m_mm   = 0;
      for (int p = 0; p < P; p++)
         for (int e = 0; e < E; e++)
            if (n != 0 && card[p][e] == n) begin
               card[p][e] = 0;
               m_mm = m_mm | (1 << p);
            end
      m_wm = 0;
      for (int p = 0; p < P; p++)
         if (has[p] && mrem(p) == 0) m_wm = m_wm | (1 << p);
      m_over = (m_wm != 0);
      check_play("draw");
   endtask

   task automatic new_game();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      model_clear();
      check_idle("new_game");
   endtask

   task automatic set_ld(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3);
      ld[0] = a0; ld[1] = a1; ld[2] = a2; ld[3] = a3;
      ld[4] = b0; ld[5] = b1; ld[6] = b2; ld[7] = b3;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();

      // Load and start, with a start pulse mid-load that must be ignored.
      set_ld(1, 2, 3, 4, 3, 5, 6, 7);
      load_card(1'b1, 1'b0);
      do_start();
      chk("start_rem_44", 32'(remaining), 32'h24);

      // load_valid in PLAY does nothing.
      @(negedge clk); load_valid = 1'b1; load_number = 8'd3;
      repeat (3) @(negedge clk);
      load_valid = 1'b0;
      chk("play_load_ignored_rem", 32'(remaining), 32'(exp_rem()));
      chk("play_load_ready",       32'(load_ready), 0);
      chk("play_still_ready",      32'(draw_ready), 1);

      // Shared match.
      do_draw(3);
      chk("shared_mm",   32'(match_mask), 32'h3);
      chk("shared_rem",  32'(remaining), 32'h1B);
      chk("shared_last", 32'(last_draw), 32'd3);

      // Miss, re-draw, zero.
      do_draw(9);
      do_draw(3);
      do_draw(0);
      chk("zero_mm",  32'(match_mask), 0);
      chk("zero_rem", 32'(remaining), 32'h1B);

      // Single winner.
      do_draw(1);
      do_draw(2);
      do_draw(4);
      chk("single_wm",   32'(winner_mask), 32'h1);
      chk("single_over", 32'(game_over), 1);
      do_draw(5);
      new_game();

      // Tie and duplicates.
      set_ld(1, 1, 2, 2, 2, 1, 2, 1);
      load_card(1'b0, 1'b0);
      do_start();
      do_draw(1);
      chk("dup_rem", 32'(remaining), 32'h12);
      do_draw(2);
      chk("tie_wm", 32'(winner_mask), 32'h3);
      new_game();

      // Reset mid-scan.
      set_ld(1, 2, 3, 4, 3, 5, 6, 7);
      load_card(1'b0, 1'b0);
      do_start();
      @(negedge clk); draw_valid = 1'b1; draw_number = 8'd3;
      @(negedge clk); draw_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      model_clear();
      check_idle("midscan_reset");
      set_ld(1, 2, 3, 4, 3, 5, 6, 7);
      load_card(1'b0, 1'b0);
      do_start();
      chk("after_reset_rem", 32'(remaining), 32'h24);
      do_draw(3);
      chk("after_reset_mm", 32'(match_mask), 32'h3);

      // Randomized games.
      for (int g = 0; g < 6; g++) begin
         do_reset();
         for (int i = 0; i < N; i++) ld[i] = $urandom_range(0, 6);
         load_card(1'($urandom_range(0, 1)), 1'b1);
         do_start();
         for (int d = 0; d < 20 && !m_over; d++) do_draw($urandom_range(0, 7));
         if (m_over) begin
            do_draw($urandom_range(1, 7));
            new_game();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
